// File: rtl/bip_pkg.sv
// Shared constants and types for the buzzer tone detector and generator.
package bip_pkg;

    // Nominal half-period of the 1 kHz buzzer tone at 50 MHz.
    localparam int HALF_PERIOD_1KHZ = 25000;

    // Default accepted deviation per half-period (5 % of nominal).
    localparam int TOL_DEFAULT = 1250;

    // Detector state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } bip_state_t;

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bipdetect_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a previous-value
// register so rising/falling transitions of the synchronized level can be
// detected. Also used for the push-button inputs.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic s_reg;
    logic s_d_reg;

    // Metastability chain followed by the one-cycle-delayed copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b0;
            s_reg    <= 1'b0;
            s_d_reg  <= 1'b0;
        end else begin
            meta_reg <= d;
            s_reg    <= meta_reg;
            s_d_reg  <= s_reg;
        end
    end

    assign s    = s_reg;
    assign rise = s_reg & ~s_d_reg;
    assign fall = ~s_reg & s_d_reg;

endmodule

// File: rtl/bipdetect.sv
// Tone detector: measures half-periods of a synchronized square wave, locks
// after a run of in-tolerance halves, reports the full period while locked
// and counts lock events (beeps).
module bipdetect
    import bip_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_1KHZ,
    parameter int TOL         = TOL_DEFAULT,
    parameter int LOCK_HALVES = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tone_in,
    output logic             tone_present,
    output logic [CNT_W:0]   period,
    output logic             period_valid,
    output logic [7:0]       beep_count
);

    localparam int GC_W = $clog2(LOCK_HALVES + 1);
    localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(HALF_PERIOD - TOL);
    localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(HALF_PERIOD + TOL + 1);
    localparam logic [GC_W-1:0]  LOCK_CNT = GC_W'(LOCK_HALVES);
    localparam logic [GC_W-1:0]  LAST_ACQ = GC_W'(LOCK_HALVES - 1);

    logic             s;
    logic             rise;
    logic             fall;
    logic             edge_det;

    logic [CNT_W-1:0] run_len_reg;
    logic [CNT_W-1:0] last_high_reg;
    logic [CNT_W-1:0] last_low_reg;
    logic [CNT_W-1:0] h;
    logic             good;
    logic             timeout;

    bip_state_t       state_reg;
    bip_state_t       state_next;
    logic [GC_W-1:0]  good_cnt_reg;
    logic [GC_W-1:0]  good_cnt_next;
    logic             lock_evt;
    logic             period_upd;

    logic [CNT_W:0]   period_reg;
    logic             period_valid_reg;
    logic [7:0]       beep_count_reg;

    sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (tone_in),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    assign edge_det = rise | fall;
    assign h        = run_len_reg;
    assign good     = (h >= LO_LIM) && (h <= HI_LIM);
    // An edge restarts the run, so it takes precedence over a stuck-line timeout.
    assign timeout  = !edge_det && (run_len_reg == TO_LIM);

    // Run-length counter and per-level capture of the completed run.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_len_reg   <= '0;
            last_high_reg <= '0;
            last_low_reg  <= '0;
        end else if (!enable) begin
            run_len_reg <= '0;
        end else if (edge_det) begin
            run_len_reg <= CNT_W'(1);
            // s is already the new level, so the finished run had the opposite one.
            if (s) begin
                last_low_reg <= h;
            end else begin
                last_high_reg <= h;
            end
        end else if (run_len_reg != '1) begin
            run_len_reg <= run_len_reg + CNT_W'(1);
        end
    end

    // State and qualified-halves counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            good_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            good_cnt_reg <= good_cnt_next;
        end
    end

    // Next-state logic; also flags lock events and period updates.
    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        lock_evt      = 1'b0;
        period_upd    = 1'b0;
        if (!enable) begin
            state_next    = ST_IDLE;
            good_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // The run ending here started before we were watching.
                    if (edge_det) begin
                        state_next    = ST_ACQ;
                        good_cnt_next = '0;
                    end
                end
                ST_ACQ: begin
                    if (edge_det) begin
                        if (good) begin
                            if (good_cnt_reg == LAST_ACQ) begin
                                state_next    = ST_LOCKED;
                                good_cnt_next = LOCK_CNT;
                                lock_evt      = 1'b1;
                                period_upd    = rise;
                            end else begin
                                good_cnt_next = good_cnt_reg + GC_W'(1);
                            end
                        end else begin
                            good_cnt_next = '0;
                        end
                    end else if (timeout) begin
                        state_next    = ST_IDLE;
                        good_cnt_next = '0;
                    end
                end
                ST_LOCKED: begin
                    if (edge_det) begin
                        if (good) begin
                            period_upd = rise;
                        end else begin
                            state_next    = ST_ACQ;
                            good_cnt_next = '0;
                        end
                    end else if (timeout) begin
                        state_next    = ST_IDLE;
                        good_cnt_next = '0;
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    good_cnt_next = '0;
                end
            endcase
        end
    end

    // Measured period, its strobe and the saturating beep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            beep_count_reg   <= '0;
        end else begin
            period_valid_reg <= period_upd;
            if (period_upd) begin
                period_reg <= {1'b0, h} + {1'b0, last_high_reg};
            end
            if (lock_evt) begin
                beep_count_reg <= sat_inc8(beep_count_reg);
            end
        end
    end

    // Output decode.
    always_comb begin
        tone_present = (state_reg == ST_LOCKED);
        period       = period_reg;
        period_valid = period_valid_reg;
        beep_count   = beep_count_reg;
    end

endmodule

// File: tb/tb_bipdetect.sv
// Directed bench for bipdetect with HALF_PERIOD=10, TOL=1, LOCK_HALVES=4.
// Inputs change on the falling clock edge; outputs are read there too.
module tb_bipdetect;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tone_in;
    logic        tone_present;
    logic [16:0] period;
    logic        period_valid;
    logic [7:0]  beep_count;

    int total = 0;
    int bad   = 0;
    int pv_cnt = 0;
    int tp_cnt = 0;
    logic lvl = 1'b0;

    bipdetect #(
        .HALF_PERIOD (10),
        .TOL         (1),
        .LOCK_HALVES (4),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .tone_in      (tone_in),
        .tone_present (tone_present),
        .period       (period),
        .period_valid (period_valid),
        .beep_count   (beep_count)
    );

    always #5 clk = ~clk;

    // Cycle counters for strobe / lock activity, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (period_valid === 1'b1) pv_cnt++;
        if (tone_present === 1'b1) tp_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one level for n cycles.
    task automatic half(input logic l, input int n);
        tone_in = l;
        lvl = l;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; tone_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tone_in = ~tone_in;
            @(negedge clk);
            total++;
            if ({tone_present, period, period_valid, beep_count} !== 27'd0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got tp=%b period=%0d pv=%b beep=%0d want all 0",
                         i, tone_present, period, period_valid, beep_count);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) tone_in = ~tone_in;
            @(negedge clk);
        end
        total++;
        if ({tone_present, period, period_valid, beep_count} !== 27'd0) begin
            bad++;
            $display("FAIL reset_disabled: got tp=%b period=%0d pv=%b beep=%0d want all 0",
                     tone_present, period, period_valid, beep_count);
        end
        tone_in = 1'b0; lvl = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_out_of_tol;
        int pv0, tp0;
        pv0 = pv_cnt; tp0 = tp_cnt;
        for (int i = 0; i < 4; i++) half(~lvl, 13);
        for (int i = 0; i < 8; i++) half(~lvl, 7);
        total++;
        if (tp_cnt - tp0 !== 0) begin
            bad++;
            $display("FAIL oot_tone_present: got %0d locked cycles want 0", tp_cnt - tp0);
        end
        total++;
        if (pv_cnt - pv0 !== 0) begin
            bad++;
            $display("FAIL oot_period_valid: got %0d strobes want 0", pv_cnt - pv0);
        end
        total++;
        if (beep_count !== 8'd0) begin
            bad++;
            $display("FAIL oot_beep: got %0d want 0", beep_count);
        end
        // Hold the line so the detector times out back to idle.
        repeat (20) @(negedge clk);
        $display("test_out_of_tol done");
    endtask

    task automatic test_nominal;
        int pv0;
        half(1'b1, 10); half(1'b0, 10); half(1'b1, 10); half(1'b0, 10);
        tone_in = 1'b1; lvl = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (tone_present !== 1'b0) begin
            bad++;
            $display("FAIL nom_prelock: got tp=%b want 0", tone_present);
        end
        @(negedge clk);
        total++;
        if ({tone_present, period_valid, period, beep_count} !== {1'b1, 1'b1, 17'd20, 8'd1}) begin
            bad++;
            $display("FAIL nom_lock: got tp=%b pv=%b period=%0d beep=%0d want tp=1 pv=1 period=20 beep=1",
                     tone_present, period_valid, period, beep_count);
        end
        repeat (7) @(negedge clk);
        pv0 = pv_cnt;
        for (int i = 0; i < 3; i++) begin
            half(1'b0, 10); half(1'b1, 10);
        end
        total++;
        if (pv_cnt - pv0 !== 3) begin
            bad++;
            $display("FAIL nom_strobes: got %0d want 3", pv_cnt - pv0);
        end
        total++;
        if ({tone_present, period} !== {1'b1, 17'd20}) begin
            bad++;
            $display("FAIL nom_period: got tp=%b period=%0d want tp=1 period=20", tone_present, period);
        end
        $display("test_nominal done");
    endtask

    task automatic test_wobble;
        half(1'b0, 9);
        tone_in = 1'b1; lvl = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({period_valid, period} !== {1'b1, 17'd19}) begin
            bad++;
            $display("FAIL wob_mixed: got pv=%b period=%0d want pv=1 period=19", period_valid, period);
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            half(1'b0, 9); half(1'b1, 11);
        end
        total++;
        if ({tone_present, period, beep_count} !== {1'b1, 17'd20, 8'd1}) begin
            bad++;
            $display("FAIL wob_steady: got tp=%b period=%0d beep=%0d want tp=1 period=20 beep=1",
                     tone_present, period, beep_count);
        end
        $display("test_wobble done");
    endtask

    task automatic test_timeout;
        int pv0;
        half(1'b0, 10);
        tone_in = 1'b1; lvl = 1'b1;
        repeat (14) @(negedge clk);
        total++;
        if (tone_present !== 1'b1) begin
            bad++;
            $display("FAIL to_before: got tp=%b want 1", tone_present);
        end
        @(negedge clk);
        total++;
        if ({tone_present, beep_count} !== {1'b0, 8'd1}) begin
            bad++;
            $display("FAIL to_drop: got tp=%b beep=%0d want tp=0 beep=1", tone_present, beep_count);
        end
        half(1'b0, 10); half(1'b1, 10); half(1'b0, 10); half(1'b1, 10);
        pv0 = pv_cnt;
        half(1'b0, 10);
        total++;
        if ({tone_present, beep_count} !== {1'b1, 8'd2}) begin
            bad++;
            $display("FAIL to_relock: got tp=%b beep=%0d want tp=1 beep=2", tone_present, beep_count);
        end
        total++;
        if (pv_cnt - pv0 !== 0) begin
            bad++;
            $display("FAIL to_fall_lock_strobe: got %0d strobes want 0", pv_cnt - pv0);
        end
        $display("test_timeout done");
    endtask

    task automatic test_glitch;
        half(1'b1, 10);
        half(1'b0, 3);
        tone_in = 1'b1; lvl = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (tone_present !== 1'b1) begin
            bad++;
            $display("FAIL gl_before: got tp=%b want 1", tone_present);
        end
        @(negedge clk);
        total++;
        if ({tone_present, beep_count} !== {1'b0, 8'd2}) begin
            bad++;
            $display("FAIL gl_drop: got tp=%b beep=%0d want tp=0 beep=2", tone_present, beep_count);
        end
        repeat (7) @(negedge clk);
        half(1'b0, 10); half(1'b1, 10); half(1'b0, 10);
        tone_in = 1'b1; lvl = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({tone_present, beep_count, period_valid, period} !== {1'b1, 8'd3, 1'b1, 17'd20}) begin
            bad++;
            $display("FAIL gl_relock: got tp=%b beep=%0d pv=%b period=%0d want tp=1 beep=3 pv=1 period=20",
                     tone_present, beep_count, period_valid, period);
        end
        repeat (7) @(negedge clk);
        $display("test_glitch done");
    endtask

    task automatic test_enable_drop;
        half(1'b0, 10);
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({tone_present, period_valid, period, beep_count} !== {1'b0, 1'b0, 17'd20, 8'd3}) begin
            bad++;
            $display("FAIL en_drop: got tp=%b pv=%b period=%0d beep=%0d want tp=0 pv=0 period=20 beep=3",
                     tone_present, period_valid, period, beep_count);
        end
        enable = 1'b1;
        half(1'b1, 10); half(1'b0, 10); half(1'b1, 10); half(1'b0, 10);
        total++;
        if (tone_present !== 1'b0) begin
            bad++;
            $display("FAIL en_prelock: got tp=%b want 0", tone_present);
        end
        half(1'b1, 10);
        total++;
        if ({tone_present, beep_count} !== {1'b1, 8'd4}) begin
            bad++;
            $display("FAIL en_relock: got tp=%b beep=%0d want tp=1 beep=4", tone_present, beep_count);
        end
        $display("test_enable_drop done");
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            enable = 1'b0;
            @(negedge clk);
            enable = 1'b1;
            for (int j = 0; j < 5; j++) half(~lvl, 10);
            if (i == 249) begin
                total++;
                if (beep_count !== 8'd254) begin
                    bad++;
                    $display("FAIL sat_254: got %0d want 254", beep_count);
                end
            end
        end
        total++;
        if ({tone_present, beep_count} !== {1'b1, 8'd255}) begin
            bad++;
            $display("FAIL sat_255: got tp=%b beep=%0d want tp=1 beep=255", tone_present, beep_count);
        end
        $display("test_saturation done");
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; tone_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_out_of_tol();
        test_nominal();
        test_wobble();
        test_timeout();
        test_glitch();
        test_enable_drop();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
